// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - b_in one bit per clock, LSB first.
// Optional macro SERIAL_SUB_SAT_EN clamps diff to zero when the result borrows.
module serial_subtractor #(
    parameter int IP_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IP_WIDTH-1:0] a,
    input  logic [IP_WIDTH-1:0] b,
    input  logic                b_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IP_WIDTH-1:0] diff,
    output logic                b_out
);

    localparam int CW = $clog2(IP_WIDTH) + 1;

    // Handshake rule: a transfer happens on a rising edge where valid and ready are both high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [IP_WIDTH-1:0] a_sh;
    logic [IP_WIDTH-1:0] b_sh;
    logic [IP_WIDTH-1:0] res_sh;
    logic [IP_WIDTH-1:0] res_next;
    logic [CW-1:0]       cnt;
    logic                br;
    logic                br_next;
    logic                d;
    logic                last;
    logic                b_out_q;

    assign d       = a_sh[0] ^ b_sh[0] ^ br;
    assign br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    assign last    = (cnt == CW'(IP_WIDTH - 1));

    generate
        if (IP_WIDTH == 1) begin : g_res_one
            assign res_next = d;
        end else begin : g_res_multi
            assign res_next = {d, res_sh[IP_WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        b_out     = b_out_q;
`ifdef SERIAL_SUB_SAT_EN
        diff      = (state == DONE && b_out_q) ? '0 : res_sh;
`else
        diff      = res_sh;
`endif
    end

    // res_sh only moves during RUN, so diff holds its last value through DONE and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            br      <= 1'b0;
            cnt     <= '0;
            b_out_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh <= a;
                        b_sh <= b;
                        br   <= b_in;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    br     <= br_next;
                    cnt    <= cnt + CW'(1);
                    if (last) b_out_q <= br_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: 8-bit and 1-bit instances checked against an arithmetic model.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       b_in = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       in_ready;
    logic       out_valid;
    logic       b_out;
    logic [7:0] diff;

    logic       in_valid1 = 1'b0;
    logic       out_ready1 = 1'b0;
    logic       b_in1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       in_ready1;
    logic       out_valid1;
    logic       b_out1;
    logic [0:0] diff1;

    int total = 0;
    int bad = 0;
    logic [8:0] exp_q[$];
    logic [1:0] exp1_q[$];

    serial_subtractor #(.IP_WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .b_out(b_out)
    );

    serial_subtractor #(.IP_WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .b_in(b_in1), .out_valid(out_valid1), .out_ready(out_ready1),
        .diff(diff1), .b_out(b_out1)
    );

    // Reference: plain integer subtraction; borrow is a negative result.
    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic bi);
        int t;
        logic [7:0] dd;
        t  = int'(x) - int'(y) - int'(bi);
        dd = t[7:0];
`ifdef SERIAL_SUB_SAT_EN
        if (t < 0) dd = '0;
`endif
        return {t < 0, dd};
    endfunction

    function automatic logic [1:0] model1(input logic x, input logic y, input logic bi);
        int t;
        logic dd;
        t  = int'(x) - int'(y) - int'(bi);
        dd = t[0];
`ifdef SERIAL_SUB_SAT_EN
        if (t < 0) dd = 1'b0;
`endif
        return {t < 0, dd};
    endfunction

    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic bi);
        logic [8:0] e;
        int n;
        e = model8(x, y, bi);
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL op_ready: in_ready=%0b required 1", in_ready);
        end
        a = x; b = y; b_in = bi; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); b_in = 1'($urandom);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        total++;
        if (n !== 8) begin
            bad++; $display("FAIL op_latency: edges=%0d required 8", n);
        end
        total++;
        if ({b_out, diff} !== e) begin
            bad++; $display("FAIL op_result a=%0h b=%0h bin=%0b: b_out/diff=%0b/%0h required %0b/%0h",
                            x, y, bi, b_out, diff, e[8], e[7:0]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++; $display("FAIL op_release: out_valid/in_ready=%0b/%0b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: %0b required 1", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: %0b required 0", out_valid); end
        total++;
        if ({b_out, diff} !== 9'h000) begin
            bad++; $display("FAIL reset_outputs: b_out/diff=%0b/%0h required 0/0", b_out, diff);
        end
        total++;
        if ({in_ready1, out_valid1} !== 2'b10) begin
            bad++; $display("FAIL reset_w1: in_ready/out_valid=%0b/%0b required 1/0", in_ready1, out_valid1);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_op(8'd200, 8'd55, 1'b0);
        run_op(8'd5, 8'd10, 1'b0);
        run_op(8'h00, 8'h00, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b0);
        run_op(8'h00, 8'hFF, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_backpressure();
        logic [8:0] e;
        int n;
        a = 8'd100; b = 8'd37; b_in = 1'b1; in_valid = 1'b1;
        e = model8(8'd100, 8'd37, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid; a = 8'($urandom); b = 8'($urandom);
            @(posedge clk); #1;
            total++;
            if ({out_valid, in_ready} !== 2'b10) begin
                bad++; $display("FAIL bp_hold_flags cyc%0d: out_valid/in_ready=%0b/%0b required 1/0",
                                i, out_valid, in_ready);
            end
            total++;
            if ({b_out, diff} !== e) begin
                bad++; $display("FAIL bp_hold_data cyc%0d: b_out/diff=%0b/%0h required %0b/%0h",
                                i, b_out, diff, e[8], e[7:0]);
            end
        end
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++; $display("FAIL bp_release: out_valid/in_ready=%0b/%0b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++; $display("FAIL midreset_flags: out_valid/in_ready=%0b/%0b required 0/1", out_valid, in_ready);
        end
        total++;
        if (diff !== 8'h00) begin bad++; $display("FAIL midreset_diff: %0h required 0", diff); end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'h80, 8'h01, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] x, y;
        logic bi;
        logic [8:0] got;
        int prev, accepts, c;
        prev = -1; accepts = 0; c = 0;
        out_ready = 1'b1;
        while (!(accepts == 5 && exp_q.size() == 0) && c < 120) begin
            if (accepts == 5) in_valid = 1'b0;
            if (out_valid) begin
                got = {b_out, diff};
                total++;
                if (exp_q.size() == 0 || got !== exp_q[0]) begin
                    bad++; $display("FAIL b2b_result: b_out/diff=%0b/%0h required %0h", b_out, diff,
                                    (exp_q.size() > 0) ? exp_q[0] : 9'h1FF);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (in_ready && accepts < 5) begin
                if (prev >= 0) begin
                    total++;
                    if (c - prev !== 10) begin
                        bad++; $display("FAIL b2b_spacing: cycles=%0d required 10", c - prev);
                    end
                end
                prev = c;
                x = 8'($urandom); y = 8'($urandom); bi = 1'($urandom);
                a = x; b = y; b_in = bi; in_valid = 1'b1;
                exp_q.push_back(model8(x, y, bi));
                accepts++;
            end
            @(posedge clk); #1;
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        total++;
        if (exp_q.size() !== 0 || accepts !== 5) begin
            bad++; $display("FAIL b2b_drain: pending=%0d accepts=%0d required 0/5", exp_q.size(), accepts);
        end
    endtask

    task automatic test_back_to_back_w1();
        logic x, y, bi;
        logic [1:0] got;
        int prev, accepts, c;
        prev = -1; accepts = 0; c = 0;
        out_ready1 = 1'b1;
        while (!(accepts == 6 && exp1_q.size() == 0) && c < 60) begin
            if (accepts == 6) in_valid1 = 1'b0;
            if (out_valid1) begin
                got = {b_out1, diff1};
                total++;
                if (exp1_q.size() == 0 || got !== exp1_q[0]) begin
                    bad++; $display("FAIL w1_result: b_out/diff=%0b/%0b required %0b", b_out1, diff1,
                                    (exp1_q.size() > 0) ? exp1_q[0] : 2'b11);
                end
                if (exp1_q.size() > 0) void'(exp1_q.pop_front());
            end
            if (in_ready1 && accepts < 6) begin
                if (prev >= 0) begin
                    total++;
                    if (c - prev !== 3) begin
                        bad++; $display("FAIL w1_spacing: cycles=%0d required 3", c - prev);
                    end
                end
                prev = c;
                if (accepts == 0) begin
                    x = 1'b0; y = 1'b1; bi = 1'b0;
                end else begin
                    x = 1'($urandom); y = 1'($urandom); bi = 1'($urandom);
                end
                a1 = x; b1 = y; b_in1 = bi; in_valid1 = 1'b1;
                exp1_q.push_back(model1(x, y, bi));
                accepts++;
            end
            @(posedge clk); #1;
            c++;
        end
        in_valid1 = 1'b0; out_ready1 = 1'b0;
        total++;
        if (exp1_q.size() !== 0 || accepts !== 6) begin
            bad++; $display("FAIL w1_drain: pending=%0d accepts=%0d required 0/6", exp1_q.size(), accepts);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_back_to_back_w1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
